// File: rtl/dmem_arbiter_pkg.sv
// Shared load/store definitions for the data-memory arbiter:
// mode encodings, size decode, legality check and response pipeline record.
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    LS_W  = 3'd0,
    LS_H  = 3'd1,
    LS_UH = 3'd2,
    LS_B  = 3'd3,
    LS_UB = 3'd4
  } ls_mode_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } ls_size_e;

  // Response pipeline stage: one entry per granted access.
  typedef struct packed {
    logic       valid;
    logic       owner_x;
    logic       read;
    logic       err;
    logic [2:0] mode;
    logic [1:0] off;
  } rsp_t;

  // Access size for a raw mode field; undefined encodings decode to SZ_NONE.
  function automatic ls_size_e ls_size(input logic [2:0] mode);
    ls_size_e sz;
    case (mode)
      LS_W:         sz = SZ_WORD;
      LS_H, LS_UH:  sz = SZ_HALF;
      LS_B, LS_UB:  sz = SZ_BYTE;
      default:      sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  // Sign-extending loads.
  function automatic logic ls_signed(input logic [2:0] mode);
    return (mode == LS_H) || (mode == LS_B);
  endfunction

  // Misaligned or undefined-mode accesses are granted but never reach the RAM.
  function automatic logic ls_illegal(input logic [2:0] mode, input logic [1:0] off);
    logic ill;
    case (ls_size(mode))
      SZ_WORD: ill = (off != 2'b00);
      SZ_HALF: ill = off[0];
      SZ_BYTE: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side load/store bus: request fields plus grant and response.
// master = requester (CPU or aux), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [2:0]            mode;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, mode, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, mode, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter_lane_fmt.sv
// Byte-lane formatting for the data memory: request side produces byte
// enables and lane-replicated store data, response side extracts and
// extends the load lane selected by the registered address offset.
module dmem_lane_fmt
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0]  i_req_mode,
  input  logic [1:0]  i_req_off,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_illegal,
  output logic [3:0]  o_req_byteena,
  output logic [31:0] o_req_wdata,
  input  logic [2:0]  i_rsp_mode,
  input  logic [1:0]  i_rsp_off,
  input  logic [31:0] i_rsp_q,
  output logic [31:0] o_rsp_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic        w_sign;

  // Request lanes: enables by size/offset, store data replicated across lanes.
  always_comb begin
    o_req_illegal = ls_illegal(i_req_mode, i_req_off);
    o_req_byteena = '0;
    o_req_wdata   = i_req_wdata;
    case (ls_size(i_req_mode))
      SZ_WORD: o_req_byteena = '1;
      SZ_HALF: begin
        o_req_byteena = i_req_off[1] ? 4'b1100 : 4'b0011;
        o_req_wdata   = {2{i_req_wdata[15:0]}};
      end
      SZ_BYTE: begin
        o_req_byteena = 4'b0001 << i_req_off;
        o_req_wdata   = {4{i_req_wdata[7:0]}};
      end
      default: o_req_byteena = '0;
    endcase
    if (o_req_illegal) o_req_byteena = '0;
  end

  // Response lanes: pick the addressed half/byte and sign- or zero-extend.
  always_comb begin
    w_half      = i_rsp_off[1] ? i_rsp_q[31:16] : i_rsp_q[15:0];
    w_byte      = i_rsp_q[{i_rsp_off, 3'b000} +: 8];
    w_sign      = ls_signed(i_rsp_mode);
    o_rsp_rdata = i_rsp_q;
    case (ls_size(i_rsp_mode))
      SZ_HALF: o_rsp_rdata = {{16{w_sign & w_half[15]}}, w_half};
      SZ_BYTE: o_rsp_rdata = {{24{w_sign & w_byte[7]}}, w_byte};
      default: o_rsp_rdata = i_rsp_q;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU + aux loader/debug) in front of a
// single-port synchronous RAM with one-cycle read latency.
// Build option DMEM_ARB_RR_EN: round-robin arbitration; otherwise fixed
// CPU priority with an aux starvation counter limited by STARVE_MAX.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         c,
  dmem_arbiter_if.slave         x,
  output logic [14:0]           m_addr,
  output logic [3:0]            m_byteena,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wren,
  input  logic [DATA_WIDTH-1:0] m_q
);

  logic        w_c_req, w_x_req;
  logic        w_c_gnt, w_x_gnt, w_any_gnt;
  logic        w_x_prio;
  logic        w_sel_we;
  logic [2:0]  w_sel_mode;
  logic [16:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_fmt_illegal;
  logic [3:0]  w_fmt_be;
  logic [31:0] w_fmt_wdata;
  logic [31:0] w_fmt_rdata;
  logic [31:0] w_rsp_data;
  logic        w_rsp_live;
  rsp_t        r_rsp;

  // Requests are masked during reset so nothing is granted in that cycle.
  assign w_c_req = c.req & ~rst;
  assign w_x_req = x.req & ~rst;

`ifdef DMEM_ARB_RR_EN
  logic r_rr_x_next;

  // Round-robin pointer: the port not granted last wins the next contention.
  always_ff @(posedge clk) begin
    if (rst)          r_rr_x_next <= 1'b0;
    else if (w_c_gnt) r_rr_x_next <= 1'b1;
    else if (w_x_gnt) r_rr_x_next <= 1'b0;
  end

  assign w_x_prio = r_rr_x_next;
`else
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  // Consecutive CPU grants while aux waits; saturates at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst || w_x_gnt || !w_x_req)
      r_starve <= '0;
    else if (w_c_gnt && (r_starve != SW'(STARVE_MAX)))
      r_starve <= r_starve + 1'b1;
  end

  assign w_x_prio = (r_starve == SW'(STARVE_MAX));
`endif

  // A lone requester always wins; priority only matters on contention.
  assign w_x_gnt   = w_x_req & (~w_c_req | w_x_prio);
  assign w_c_gnt   = w_c_req & ~w_x_gnt;
  assign w_any_gnt = w_c_gnt | w_x_gnt;
  assign c.gnt     = w_c_gnt;
  assign x.gnt     = w_x_gnt;

  // Winner's request fields.
  always_comb begin
    if (w_x_gnt) begin
      w_sel_we    = x.we;
      w_sel_mode  = x.mode;
      w_sel_addr  = x.addr[16:0];
      w_sel_wdata = x.wdata;
    end else begin
      w_sel_we    = c.we;
      w_sel_mode  = c.mode;
      w_sel_addr  = c.addr[16:0];
      w_sel_wdata = c.wdata;
    end
  end

  dmem_lane_fmt u_lane_fmt (
    .i_req_mode    (w_sel_mode),
    .i_req_off     (w_sel_addr[1:0]),
    .i_req_wdata   (w_sel_wdata),
    .o_req_illegal (w_fmt_illegal),
    .o_req_byteena (w_fmt_be),
    .o_req_wdata   (w_fmt_wdata),
    .i_rsp_mode    (r_rsp.mode),
    .i_rsp_off     (r_rsp.off),
    .i_rsp_q       (m_q),
    .o_rsp_rdata   (w_fmt_rdata)
  );

  // RAM port driven only by a grant; illegal accesses leave enables at zero.
  always_comb begin
    m_addr    = '0;
    m_byteena = '0;
    m_wdata   = '0;
    m_wren    = 1'b0;
    if (w_any_gnt) begin
      m_addr    = w_sel_addr[16:2];
      m_byteena = w_fmt_be;
      m_wdata   = w_fmt_wdata;
      m_wren    = w_sel_we & ~w_fmt_illegal;
    end
  end

  // Response pipeline: one entry per grant, dropped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid   <= w_any_gnt;
      r_rsp.owner_x <= w_x_gnt;
      r_rsp.read    <= ~w_sel_we;
      r_rsp.err     <= w_fmt_illegal;
      r_rsp.mode    <= w_sel_mode;
      r_rsp.off     <= w_sel_addr[1:0];
    end
  end

  // Response steering: rvalid is also masked while rst is high so a response
  // pending from the cycle before reset never appears on the outputs.
  always_comb begin
    w_rsp_live = r_rsp.valid & ~rst;
    w_rsp_data = (r_rsp.read & ~r_rsp.err) ? w_fmt_rdata : '0;
    c.rvalid   = w_rsp_live & ~r_rsp.owner_x;
    c.err      = w_rsp_live & ~r_rsp.owner_x & r_rsp.err;
    c.rdata    = (w_rsp_live & ~r_rsp.owner_x) ? w_rsp_data : '0;
    x.rvalid   = w_rsp_live & r_rsp.owner_x;
    x.err      = w_rsp_live & r_rsp.owner_x & r_rsp.err;
    x.rdata    = (w_rsp_live & r_rsp.owner_x) ? w_rsp_data : '0;
  end

endmodule
